// File: rtl/lzc_rr_arbiter_if.sv
// Request/response bundle for lzc_rr_arbiter. The rsp_norm field exists only when LZC_NORM_EN
// is defined.
interface lzc_rr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*32-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDX_W-1:0]      rsp_id;
    logic [4:0]            rsp_msb_idx;
    logic [5:0]            rsp_lz;
    logic                  rsp_zero;
`ifdef LZC_NORM_EN
    logic [31:0]           rsp_norm;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_msb_idx, rsp_lz, rsp_zero, rsp_norm
    );
    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_msb_idx, rsp_lz, rsp_zero, rsp_norm
    );
`else
    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_msb_idx, rsp_lz, rsp_zero
    );
    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_msb_idx, rsp_lz, rsp_zero
    );
`endif
endinterface

// File: rtl/lzc_rr_arbiter.sv
// Round-robin arbiter sharing one 32-bit leading-zero counter among NUM_REQ requesters, with a
// single registered result slot. Define LZC_NORM_EN to add the normalising left shift (rsp_norm).
module lzc_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input logic               clk,
    input logic               rst,
    lzc_rr_arbiter_if.slave   bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] rr_ptr_q;
    logic             rsp_valid_q;
    logic [IDX_W-1:0] rsp_id_q;
    logic [4:0]       rsp_msb_idx_q;
    logic [5:0]       rsp_lz_q;
    logic             rsp_zero_q;

    logic [IDX_W-1:0] grant_idx;
    logic             grant_found;
    logic             slot_free;
    logic             accept;
    logic [31:0]      lzc_in;
    logic [4:0]       lzc_c;
    logic             lzc_v;
    logic [5:0]       lz;

    // Search starts at rr_ptr and wraps; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && bus.req_valid[(32'(rr_ptr_q) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign slot_free     = ~rsp_valid_q | bus.rsp_ready;
    assign accept        = grant_found & slot_free & ~rst;
    assign bus.req_ready = accept ? (NUM_REQ'(1) << grant_idx) : '0;
    assign lzc_in        = grant_found ? bus.req_data[32'(grant_idx) * 32 +: 32] : 32'h0;

    // Leading-one detector: the highest set bit is the last one to overwrite lzc_c.
    always_comb begin
        lzc_v = |lzc_in;
        lzc_c = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (lzc_in[i]) begin
                lzc_c = 5'(i);
            end
        end
    end

    assign lz = lzc_v ? (6'd31 - {1'b0, lzc_c}) : 6'd32;

`ifdef LZC_NORM_EN
    logic [31:0] norm;
    logic [31:0] rsp_norm_q;

    assign norm         = lzc_v ? (lzc_in << lz) : 32'h0;
    assign bus.rsp_norm = rsp_norm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_norm_q <= 32'h0;
        end else if (accept) begin
            rsp_norm_q <= norm;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_msb_idx_q <= 5'd0;
            rsp_lz_q      <= 6'd0;
            rsp_zero_q    <= 1'b0;
        end else if (accept) begin
            rr_ptr_q      <= IDX_W'((32'(grant_idx) + 1) % NUM_REQ);
            rsp_valid_q   <= 1'b1;
            rsp_id_q      <= grant_idx;
            rsp_msb_idx_q <= lzc_c;
            rsp_lz_q      <= lz;
            rsp_zero_q    <= ~lzc_v;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q   <= 1'b0;
        end
    end

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_id      = rsp_id_q;
    assign bus.rsp_msb_idx = rsp_msb_idx_q;
    assign bus.rsp_lz      = rsp_lz_q;
    assign bus.rsp_zero    = rsp_zero_q;
endmodule

// File: tb/tb_lzc_rr_arbiter.sv
// Randomised bench for lzc_rr_arbiter against a cycle-level reference model (queue-free:
// rotating priority plus leading-zero counting by scanning bits).
module tb_lzc_rr_arbiter;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [N-1:0] lane_valid;
    logic [31:0] lane_data [N];
    logic        rdy;

    always #5 clk = ~clk;

    lzc_rr_arbiter_if #(.NUM_REQ(N)) bus ();

    lzc_rr_arbiter #(.NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.req_valid = lane_valid;
    assign bus.rsp_ready = rdy;
    always_comb begin
        for (int i = 0; i < N; i++) bus.req_data[32*i +: 32] = lane_data[i];
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit          m_known = 0;
    bit          m_valid = 0;
    int          m_ptr   = 0;
    int          m_id    = 0;
    int          m_lz    = 0;
    int          m_msb   = 0;
    bit          m_zero  = 0;
    logic [31:0] m_norm  = 32'h0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int count_lz(input logic [31:0] d);
        for (int b = 31; b >= 0; b--) begin
            if (d[b]) return 31 - b;
        end
        return 32;
    endfunction

    // One clock: check req_ready before the edge, advance the model, check the slot after.
    task automatic step();
        int          g;
        bit          free;
        logic [N-1:0] exp_ready;
        #1;
        g    = -1;
        free = !m_valid || rdy;
        if (!rst && free) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && lane_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        if (m_known || rst) check_eq("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        @(posedge clk);
        if (rst) begin
            m_known = 1; m_valid = 0; m_ptr = 0; m_id = 0;
            m_lz = 0; m_msb = 0; m_zero = 0; m_norm = 32'h0;
        end else if (m_known) begin
            if (g >= 0) begin
                m_valid = 1;
                m_id    = g;
                m_lz    = count_lz(lane_data[g]);
                m_zero  = (m_lz == 32);
                m_msb   = m_zero ? 0 : 31 - m_lz;
                m_norm  = m_zero ? 32'h0 : (lane_data[g] << m_lz);
                m_ptr   = (g + 1) % N;
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
        end
        @(negedge clk);
        if (g >= 0) lane_valid[g] = 1'b0;
        if (m_known) begin
            check_eq("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
            check_eq("rsp_id", 64'(bus.rsp_id), 64'(m_id));
            check_eq("rsp_lz", 64'(bus.rsp_lz), 64'(m_lz));
            check_eq("rsp_zero", 64'(bus.rsp_zero), 64'(m_zero));
            if (!m_zero) check_eq("rsp_msb_idx", 64'(bus.rsp_msb_idx), 64'(m_msb));
`ifdef LZC_NORM_EN
            check_eq("rsp_norm", 64'(bus.rsp_norm), 64'(m_norm));
`endif
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'h1 << $urandom_range(0, 31);
            2:       return r;
            default: return r >> $urandom_range(0, 31);
        endcase
    endfunction

    task automatic refill_all();
        for (int i = 0; i < N; i++) begin
            if (!lane_valid[i]) begin
                lane_valid[i] = 1'b1;
                lane_data[i]  = rand_operand();
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        rdy        = 1'b1;
        lane_valid = '1;
        for (int i = 0; i < N; i++) lane_data[i] = rand_operand();

        // Reset held with every lane requesting
        step();
        step();
        rst = 1'b0;
        step();
        check_eq("first_grant_id", 64'(bus.rsp_id), 64'd0);

        // Saturated round robin, no bubbles
        for (int n = 0; n < 8; n++) begin
            refill_all();
            step();
        end

        // Drain, then directed operands
        lane_valid = '0;
        step();
        step();
        lane_valid[2] = 1'b1;
        lane_data[2]  = 32'h0001_0000;
        step();
        check_eq("dir_id2", 64'(bus.rsp_id), 64'd2);
        check_eq("dir_lz15", 64'(bus.rsp_lz), 64'd15);
        check_eq("dir_msb16", 64'(bus.rsp_msb_idx), 64'd16);
        lane_valid[1] = 1'b1;
        lane_data[1]  = 32'h0;
        step();
        check_eq("dir_zero", 64'(bus.rsp_zero), 64'd1);
        check_eq("dir_lz32", 64'(bus.rsp_lz), 64'd32);
        lane_valid[3] = 1'b1;
        lane_data[3]  = 32'h8000_0000;
        step();
        check_eq("dir_msb31", 64'(bus.rsp_msb_idx), 64'd31);
        check_eq("dir_lz0", 64'(bus.rsp_lz), 64'd0);

        // Stall with the slot full, then release
        refill_all();
        rdy = 1'b0;
        step();
        for (int n = 0; n < 3; n++) step();
        rdy = 1'b1;
        step();
        step();

        // Reset while a result is pending
        refill_all();
        rdy = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_drop", 64'(bus.rsp_valid), 64'd0);
        rdy = 1'b1;
        step();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < N; i++) begin
                if (!lane_valid[i] && $urandom_range(0, 2) == 0) begin
                    lane_valid[i] = 1'b1;
                    lane_data[i]  = rand_operand();
                end
            end
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
